// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the HD44780 line-read block.
//   state_e  : sequencer states
//   phase_e  : phases of one bus transaction
//   xkind_e  : transaction kind requested from the bus engine
package lcd_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_SET_ADDR, ST_READ, ST_DONE} state_e;
  typedef enum logic [1:0] {PH_SETUP, PH_STROBE, PH_HOLD} phase_e;
  typedef enum logic [1:0] {XK_POLL, XK_CMD, XK_READ} xkind_e;

  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
  localparam int         BF_BIT        = 7;
endpackage

// File: rtl/lcd_bus_xact.sv
// lcd_bus_xact: tick divider plus one 3-tick LCD bus transaction
// (SETUP, STROBE, HOLD; each exactly TICK_DIV clocks).
//   clk, rst_n      : clock, async active-low reset
//   run_i           : tick counter runs while high, held at 0 otherwise
//   go_i            : launch a transaction; SETUP starts on the next clock
//   rs_i/rw_i/wdata_i : transaction attributes, latched on go_i
//   lcd_db_in_i     : bus sample value
//   tick_o          : one-cycle strobe on counter wrap
//   lcd_*_o         : pin drives
//   rdata_o         : byte sampled on the last clock of STROBE
//   xact_done_o     : one-cycle pulse on the last clock of HOLD
module lcd_bus_xact
  import lcd_pkg::*;
#(
  parameter int TICK_DIV = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_i,
  input  logic       go_i,
  input  logic       rs_i,
  input  logic       rw_i,
  input  logic [7:0] wdata_i,
  input  logic [7:0] lcd_db_in_i,
  output logic       tick_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic       lcd_e_o,
  output logic [7:0] lcd_db_out_o,
  output logic       lcd_db_oe_o,
  output logic [7:0] rdata_o,
  output logic       xact_done_o
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic          active_q;
  phase_e        phase_q;
  logic          rs_q, rw_q, oe_q;
  logic [7:0]    db_q, rdata_q;

  assign tick_o      = run_i && (cnt_q == CW'(TICK_DIV - 1));
  assign xact_done_o = active_q && (phase_q == PH_HOLD) && tick_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      phase_q  <= PH_SETUP;
      rs_q     <= 1'b0;
      rw_q     <= 1'b1;
      oe_q     <= 1'b0;
      db_q     <= 8'h00;
      rdata_q  <= 8'h00;
    end else begin
      if (!run_i || tick_o) cnt_q <= '0;
      else                  cnt_q <= cnt_q + CW'(1);

      // Pin attributes only move at SETUP entry and after HOLD, both with E low.
      if (go_i && !active_q) begin
        active_q <= 1'b1;
        phase_q  <= PH_SETUP;
        rs_q     <= rs_i;
        rw_q     <= rw_i;
        oe_q     <= ~rw_i;
        db_q     <= rw_i ? 8'h00 : wdata_i;
      end else if (active_q && tick_o) begin
        case (phase_q)
          PH_SETUP:  phase_q <= PH_STROBE;
          PH_STROBE: begin
            rdata_q <= lcd_db_in_i;
            phase_q <= PH_HOLD;
          end
          default: begin
            // End of HOLD: release the bus in read mode.
            active_q <= 1'b0;
            phase_q  <= PH_SETUP;
            rs_q     <= 1'b0;
            rw_q     <= 1'b1;
            oe_q     <= 1'b0;
            db_q     <= 8'h00;
          end
        endcase
      end
    end
  end

  assign lcd_e_o      = active_q && (phase_q == PH_STROBE);
  assign lcd_rs_o     = rs_q;
  assign lcd_rw_o     = rw_q;
  assign lcd_db_oe_o  = oe_q;
  assign lcd_db_out_o = db_q;
  assign rdata_o      = rdata_q;
endmodule

// File: rtl/lcd_line_read.sv
// lcd_line_read: reads len characters starting at DDRAM address addr from
// an HD44780 LCD (set-address command, then auto-incrementing data reads).
//   clk, rst_n        : clock, async active-low reset
//   start/addr/len    : request (len clamped to MAX_LEN, len=0 completes at once)
//   busy/done         : request status; done is a one-cycle pulse
//   char_out/char_valid/char_idx : one strobe per character read
//   lcd_rs/lcd_rw/lcd_e/lcd_db_out/lcd_db_oe/lcd_db_in : LCD pins
// Build option LCD_READ_BF_POLL_EN: the gap before every transaction polls
// the busy flag instead of idling WAIT_TICKS ticks.
module lcd_line_read
  import lcd_pkg::*;
#(
  parameter int TICK_DIV   = 50,
  parameter int WAIT_TICKS = 40,
  parameter int MAX_LEN    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic [4:0] len,
  output logic       busy,
  output logic       done,
  output logic [7:0] char_out,
  output logic       char_valid,
  output logic [3:0] char_idx,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_db_out,
  output logic       lcd_db_oe,
  input  logic [7:0] lcd_db_in
);
  localparam logic [4:0] MAX_LEN_W = 5'(MAX_LEN);

  state_e     state_q, state_d;
  logic [6:0] addr_q, addr_d;
  logic [4:0] len_q, len_d;
  logic [4:0] cnt_q, cnt_d;
  logic       sent_q, sent_d;     // address command already issued
  logic [7:0] char_q, char_d;
  logic       cv_q, cv_d;
  logic [3:0] idx_q, idx_d;

  logic       go, tick, xdone;
  xkind_e     kind;
  logic [7:0] rdata;

  state_e     nxt_state;
  xkind_e     nxt_kind;
  assign nxt_state = sent_q ? ST_READ : ST_SET_ADDR;
  assign nxt_kind  = sent_q ? XK_READ : XK_CMD;

`ifndef LCD_READ_BF_POLL_EN
  localparam int WW = $clog2(WAIT_TICKS + 1);
  logic [WW-1:0] wait_q, wait_d;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    sent_d  = sent_q;
    char_d  = char_q;
    cv_d    = 1'b0;
    idx_d   = idx_q;
    go      = 1'b0;
    kind    = XK_POLL;
`ifndef LCD_READ_BF_POLL_EN
    wait_d  = wait_q;
`endif
    case (state_q)
      ST_IDLE: if (start) begin
        if (len == 5'd0) begin
          state_d = ST_DONE;
        end else begin
          addr_d  = addr;
          len_d   = (len > MAX_LEN_W) ? MAX_LEN_W : len;
          cnt_d   = 5'd0;
          sent_d  = 1'b0;
          state_d = ST_WAIT;
`ifdef LCD_READ_BF_POLL_EN
          go      = 1'b1;
`else
          wait_d  = '0;
`endif
        end
      end
      ST_WAIT: begin
`ifdef LCD_READ_BF_POLL_EN
        // Poll result is valid at the end of HOLD; launch straight into the
        // next transaction so phases stay aligned to tick boundaries.
        if (xdone) begin
          go = 1'b1;
          if (!rdata[BF_BIT]) begin
            kind    = nxt_kind;
            state_d = nxt_state;
          end
        end
`else
        if (tick) begin
          if (wait_q == WW'(WAIT_TICKS - 1)) begin
            go      = 1'b1;
            kind    = nxt_kind;
            state_d = nxt_state;
          end else begin
            wait_d = wait_q + WW'(1);
          end
        end
`endif
      end
      ST_SET_ADDR: if (xdone) begin
        sent_d  = 1'b1;
        state_d = ST_WAIT;
`ifdef LCD_READ_BF_POLL_EN
        go      = 1'b1;
`else
        wait_d  = '0;
`endif
      end
      ST_READ: if (xdone) begin
        char_d = rdata;
        cv_d   = 1'b1;
        idx_d  = cnt_q[3:0];
        cnt_d  = cnt_q + 5'd1;
        if (cnt_d == len_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
`ifdef LCD_READ_BF_POLL_EN
          go      = 1'b1;
`else
          wait_d  = '0;
`endif
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= 7'h00;
      len_q   <= 5'd0;
      cnt_q   <= 5'd0;
      sent_q  <= 1'b0;
      char_q  <= 8'h00;
      cv_q    <= 1'b0;
      idx_q   <= 4'd0;
`ifndef LCD_READ_BF_POLL_EN
      wait_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      sent_q  <= sent_d;
      char_q  <= char_d;
      cv_q    <= cv_d;
      idx_q   <= idx_d;
`ifndef LCD_READ_BF_POLL_EN
      wait_q  <= wait_d;
`endif
    end
  end

  lcd_bus_xact #(.TICK_DIV(TICK_DIV)) u_xact (
    .clk          (clk),
    .rst_n        (rst_n),
    .run_i        (state_q != ST_IDLE),
    .go_i         (go),
    .rs_i         (kind == XK_READ),
    .rw_i         (kind != XK_CMD),
    .wdata_i      (CMD_SET_DDRAM | {1'b0, addr_q}),
    .lcd_db_in_i  (lcd_db_in),
    .tick_o       (tick),
    .lcd_rs_o     (lcd_rs),
    .lcd_rw_o     (lcd_rw),
    .lcd_e_o      (lcd_e),
    .lcd_db_out_o (lcd_db_out),
    .lcd_db_oe_o  (lcd_db_oe),
    .rdata_o      (rdata),
    .xact_done_o  (xdone)
  );

  assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done       = (state_q == ST_DONE);
  assign char_out   = char_q;
  assign char_valid = cv_q;
  assign char_idx   = idx_q;
endmodule

// File: tb/tb_lcd_line_read.sv
// tb_lcd_line_read: directed bench for lcd_line_read with a small HD44780
// model (DDRAM, address counter with line wrap, busy flag).
module tb_lcd_line_read;
  localparam int TD = 4;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [6:0] addr = 7'h00;
  logic [4:0] len = 5'd0;
  logic       busy, done, char_valid, lcd_rs, lcd_rw, lcd_e, lcd_db_oe;
  logic [7:0] char_out, lcd_db_out, lcd_db_in;
  logic [3:0] char_idx;
  int pass_cnt = 0, total_cnt = 0;

  always #5 clk = ~clk;

  lcd_line_read #(.TICK_DIV(TD), .WAIT_TICKS(2), .MAX_LEN(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .len(len),
    .busy(busy), .done(done), .char_out(char_out), .char_valid(char_valid),
    .char_idx(char_idx), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .lcd_db_out(lcd_db_out), .lcd_db_oe(lcd_db_oe), .lcd_db_in(lcd_db_in)
  );

  // LCD model
  logic [7:0] mem [0:127];
  logic [6:0] ac = 7'h00;
  int poll_cnt = 0;
  int bf_until = 0;
  logic bf;
  assign bf = (poll_cnt < bf_until);
  assign lcd_db_in = (lcd_e && lcd_rw) ? (lcd_rs ? mem[ac] : {bf, ac}) : 8'h00;
  always @(negedge lcd_e) begin
    if (!lcd_rs && !lcd_rw && lcd_db_out[7]) ac <= lcd_db_out[6:0];
    else if (lcd_rs && lcd_rw) ac <= (ac == 7'h27) ? 7'h40 : (ac == 7'h67) ? 7'h00 : ac + 7'd1;
    else if (!lcd_rs && lcd_rw) poll_cnt <= poll_cnt + 1;
  end

  // Bus / output recorder
  logic [10:0] xq[$];   // {rs,rw,oe,db} at each E rise
  int          eq[$];   // E-high length per transaction
  logic [11:0] cq[$];   // {idx,char} per char_valid
  logic [1:0]  dq[$];   // {busy previous cycle, busy} at done
  logic        e_prev = 1'b0, bprev = 1'b0;
  int          e_len = 0, hold_left = 0, stab_err = 0, busy_cycles = 0;
  logic [10:0] cap = '0;
  logic [10:0] pins;
  assign pins = {lcd_rs, lcd_rw, lcd_db_oe, lcd_db_out};

  always @(negedge clk) begin
    if (!rst_n) begin
      e_prev <= 1'b0; hold_left <= 0; bprev <= 1'b0;
    end else begin
      e_prev <= lcd_e;
      bprev  <= busy;
      if (busy) busy_cycles <= busy_cycles + 1;
      if (lcd_e && !e_prev) begin
        cap <= pins; xq.push_back(pins); e_len <= 1;
      end else if (lcd_e) begin
        e_len <= e_len + 1;
        if (pins !== cap) stab_err <= stab_err + 1;
      end else if (e_prev) begin
        eq.push_back(e_len); hold_left <= TD - 1;
        if (pins !== cap) stab_err <= stab_err + 1;
      end else if (hold_left > 0) begin
        hold_left <= hold_left - 1;
        if (pins !== cap) stab_err <= stab_err + 1;
      end
      if (char_valid) cq.push_back({char_idx, char_out});
      if (done) dq.push_back({bprev, busy});
    end
  end

  task automatic do_start(input logic [6:0] a, input logic [4:0] l);
    @(negedge clk); start = 1'b1; addr = a; len = l;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n, output bit ok);
    ok = 1'b0; n = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin n = i; ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; #22;
    total_cnt++;
    if ({busy, done, char_valid, lcd_e, lcd_db_oe, lcd_rs, lcd_rw} !== 7'b0000001)
      $display("FAIL reset_ctl: got %b want 0000001", {busy, done, char_valid, lcd_e, lcd_db_oe, lcd_rs, lcd_rw});
    else pass_cnt++;
    total_cnt++;
    if ({lcd_db_out, char_out, char_idx} !== 20'h0)
      $display("FAIL reset_data: got %h want 00000", {lcd_db_out, char_out, char_idx});
    else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read_abc;
    int x0, c0, e0, d0, s0, n, bad;
    bit ok;
    logic [10:0] nq[$];
    x0 = xq.size(); c0 = cq.size(); e0 = eq.size(); d0 = dq.size(); s0 = stab_err;
    do_start(7'h05, 5'd3);
    wait_done(600, n, ok);
    total_cnt++;
    if (!ok) $display("FAIL abc_done: got timeout want done"); else pass_cnt++;
`ifndef LCD_READ_BF_POLL_EN
    total_cnt++;
    if (n !== 80) $display("FAIL abc_latency: got %0d want 80", n); else pass_cnt++;
`endif
    @(negedge clk);
    total_cnt++;
    if ({done, busy} !== 2'b00) $display("FAIL abc_done_width: got %b want 00", {done, busy});
    else pass_cnt++;
    for (int i = x0; i < xq.size(); i++)
      if (!(xq[i][10] == 1'b0 && xq[i][9] == 1'b1)) nq.push_back(xq[i]);
    total_cnt++;
    if (nq.size() !== 4) $display("FAIL abc_xact_count: got %0d want 4", nq.size());
    else pass_cnt++;
    if (nq.size() == 4) begin
      total_cnt++;
      if (nq[0] !== {3'b001, 8'h85}) $display("FAIL abc_cmd: got %h want %h", nq[0], {3'b001, 8'h85});
      else pass_cnt++;
      for (int k = 1; k < 4; k++) begin
        total_cnt++;
        if (nq[k][10:8] !== 3'b110) $display("FAIL abc_read%0d_rs_rw_oe: got %b want 110", k, nq[k][10:8]);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (cq.size() - c0 !== 3) $display("FAIL abc_char_count: got %0d want 3", cq.size() - c0);
    else pass_cnt++;
    if (cq.size() - c0 == 3)
      for (int k = 0; k < 3; k++) begin
        total_cnt++;
        if (cq[c0+k] !== {4'(k), 8'h41 + 8'(k)})
          $display("FAIL abc_char%0d: got %h want %h", k, cq[c0+k], {4'(k), 8'h41 + 8'(k)});
        else pass_cnt++;
      end
    bad = 0;
    for (int i = e0; i < eq.size(); i++) if (eq[i] != TD) bad++;
    total_cnt++;
    if (bad != 0 || eq.size() == e0) $display("FAIL abc_e_width: got %0d bad of %0d want 0 bad", bad, eq.size() - e0);
    else pass_cnt++;
    total_cnt++;
    if (stab_err !== s0) $display("FAIL abc_pin_stability: got %0d changes want 0", stab_err - s0);
    else pass_cnt++;
    total_cnt++;
    if (dq.size() != d0 + 1) $display("FAIL abc_busy_done: got %0d done pulses want 1", dq.size() - d0);
    else if (dq[d0] !== 2'b10) $display("FAIL abc_busy_done: got %b want 10", dq[d0]);
    else pass_cnt++;
  endtask

  task automatic test_len0;
    int x0, b0;
    x0 = xq.size(); b0 = busy_cycles;
    @(negedge clk); start = 1'b1; addr = 7'h10; len = 5'd0;
    @(negedge clk); start = 1'b0;
    total_cnt++;
    if ({done, busy} !== 2'b10) $display("FAIL len0_done: got %b want 10", {done, busy}); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0) $display("FAIL len0_done_width: got %b want 0", done); else pass_cnt++;
    repeat (20) @(negedge clk);
    total_cnt++;
    if (xq.size() !== x0) $display("FAIL len0_no_e: got %0d strobes want 0", xq.size() - x0); else pass_cnt++;
    total_cnt++;
    if (busy_cycles !== b0) $display("FAIL len0_busy: got %0d busy cycles want 0", busy_cycles - b0); else pass_cnt++;
  endtask

  task automatic test_wrap;
    int x0, c0, n, cmds;
    bit ok;
    logic [7:0] exp [4];
    exp = '{8'hA6, 8'hA7, 8'hC0, 8'hC1};
    x0 = xq.size(); c0 = cq.size();
    do_start(7'h26, 5'd4);
    wait_done(800, n, ok);
    total_cnt++;
    if (!ok) $display("FAIL wrap_done: got timeout want done"); else pass_cnt++;
    @(negedge clk);
    cmds = 0;
    for (int i = x0; i < xq.size(); i++) if (xq[i][9] == 1'b0) cmds++;
    total_cnt++;
    if (cmds !== 1) $display("FAIL wrap_cmd_count: got %0d want 1", cmds); else pass_cnt++;
    total_cnt++;
    if (cq.size() - c0 !== 4) $display("FAIL wrap_char_count: got %0d want 4", cq.size() - c0);
    else pass_cnt++;
    if (cq.size() - c0 == 4)
      for (int k = 0; k < 4; k++) begin
        total_cnt++;
        if (cq[c0+k] !== {4'(k), exp[k]}) $display("FAIL wrap_char%0d: got %h want %h", k, cq[c0+k], {4'(k), exp[k]});
        else pass_cnt++;
      end
  endtask

  task automatic test_clamp;
    int c0, n;
    bit ok;
    c0 = cq.size();
    do_start(7'h00, 5'd20);
    wait_done(2000, n, ok);
    total_cnt++;
    if (!ok) $display("FAIL clamp_done: got timeout want done"); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (cq.size() - c0 !== 16) $display("FAIL clamp_count: got %0d want 16", cq.size() - c0); else pass_cnt++;
    if (cq.size() - c0 == 16) begin
      total_cnt++;
      if (cq[c0+15] !== {4'hF, 8'h8F}) $display("FAIL clamp_last: got %h want f8f", cq[c0+15]); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid;
    int c0, c1, d0, rises, n;
    bit ok, found;
    logic pe;
    c0 = cq.size(); d0 = dq.size();
    do_start(7'h05, 5'd3);
    rises = 0; pe = 1'b0; found = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (lcd_e && !pe && lcd_rs) rises++;
      pe = lcd_e;
      if (rises == 2) begin found = 1'b1; break; end
    end
    total_cnt++;
    if (!found) $display("FAIL rmid_reach_read2: got timeout want second read strobe"); else pass_cnt++;
    rst_n = 1'b0; #1;
    total_cnt++;
    if ({lcd_e, lcd_db_oe, busy, char_valid, done} !== 5'b0)
      $display("FAIL rmid_abort: got %b want 00000", {lcd_e, lcd_db_oe, busy, char_valid, done});
    else pass_cnt++;
    repeat (10) @(negedge clk);
    total_cnt++;
    if (cq.size() - c0 !== 1) $display("FAIL rmid_chars: got %0d want 1", cq.size() - c0); else pass_cnt++;
    total_cnt++;
    if (dq.size() !== d0) $display("FAIL rmid_no_done: got %0d want 0", dq.size() - d0); else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    c1 = cq.size();
    do_start(7'h05, 5'd3);
    wait_done(800, n, ok);
    total_cnt++;
    if (!ok) $display("FAIL rmid_restart_done: got timeout want done"); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (cq.size() - c1 !== 3) $display("FAIL rmid_restart_count: got %0d want 3", cq.size() - c1);
    else if (cq[c1+2] !== {4'd2, 8'h43}) $display("FAIL rmid_restart_char: got %h want 243", cq[c1+2]);
    else pass_cnt++;
  endtask

`ifdef LCD_READ_BF_POLL_EN
  task automatic test_poll;
    int x0, c0, n;
    bit ok;
    x0 = xq.size(); c0 = cq.size();
    bf_until = poll_cnt + 3;
    do_start(7'h05, 5'd1);
    wait_done(800, n, ok);
    total_cnt++;
    if (!ok) $display("FAIL poll_done: got timeout want done"); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (xq.size() < x0 + 5) $display("FAIL poll_xacts: got %0d want >=5", xq.size() - x0);
    else pass_cnt++;
    if (xq.size() >= x0 + 5) begin
      for (int k = 0; k < 4; k++) begin
        total_cnt++;
        if (xq[x0+k][10:8] !== 3'b010) $display("FAIL poll%0d_rs_rw_oe: got %b want 010", k, xq[x0+k][10:8]);
        else pass_cnt++;
      end
      total_cnt++;
      if (xq[x0+4] !== {3'b001, 8'h85}) $display("FAIL poll_cmd: got %h want %h", xq[x0+4], {3'b001, 8'h85});
      else pass_cnt++;
    end
    total_cnt++;
    if (cq.size() - c0 !== 1) $display("FAIL poll_chars: got %0d want 1", cq.size() - c0);
    else if (cq[c0] !== {4'd0, 8'h41}) $display("FAIL poll_char: got %h want 041", cq[c0]);
    else pass_cnt++;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h80 | 8'(i);
    mem[5] = 8'h41; mem[6] = 8'h42; mem[7] = 8'h43;
    test_reset;
    test_read_abc;
    test_len0;
    test_wrap;
    test_clamp;
    test_reset_mid;
`ifdef LCD_READ_BF_POLL_EN
    test_poll;
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
